sp_mac_chain_ctrl: RTL and testbench

Sequencer for a 1-D systolic chain of `N_UNITS` int4×int8 double-MAC units, each computing a1·b1 + a2·b2 per pulse into a 26-bit accumulator. It takes one job at a time (start + length), clears the chain's accumulators, and accepts operand beats over a valid/ready stream. Each beat is presented to unit 0 with its precomputed `mix = b1 + b2`. After the last beat it drives zero-operand flush pulses until the beat has propagated to the last unit, then signals completion. The block sits between the operand fetch logic and the MAC chain, and is the only driver of the chain's pulse, clear and operand inputs.

---
 rtl/sp_mac_chain_ctrl_if.sv | 29 ++
 rtl/sp_mac_chain_ctrl.sv | 112 +++++++++++
 tb/tb_sp_mac_chain_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sp_mac_chain_ctrl_if.sv
// sp_mac_chain_ctrl_if: job control, operand stream and MAC-chain drive bundle
interface sp_mac_chain_ctrl_if #(parameter int KW = 16);
  logic          start;
  logic          abort;
  logic [KW-1:0] k_len;
  logic          busy;
  logic          done;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_a1;
  logic [3:0]    in_a2;
  logic [7:0]    in_b1;
  logic [7:0]    in_b2;
  logic          mac_rst;
  logic          mac_pulse;
  logic [3:0]    mac_a1;
  logic [3:0]    mac_a2;
  logic [7:0]    mac_b1;
  logic [7:0]    mac_b2;
  logic [8:0]    mac_mix;
  modport master (
    output start, abort, k_len, in_valid, in_a1, in_a2, in_b1, in_b2,
    input  busy, done, in_ready, mac_rst, mac_pulse, mac_a1, mac_a2, mac_b1, mac_b2, mac_mix
  );
  modport slave (
    input  start, abort, k_len, in_valid, in_a1, in_a2, in_b1, in_b2,
    output busy, done, in_ready, mac_rst, mac_pulse, mac_a1, mac_a2, mac_b1, mac_b2, mac_mix
  );
endinterface

// File: rtl/sp_mac_chain_ctrl.sv
// sp_mac_chain_ctrl: job sequencer feeding a systolic int4xint8 double-MAC chain
module sp_mac_chain_ctrl #(
  parameter int N_UNITS = 4,
  parameter int KW      = 16
) (
  input logic                  clk,
  input logic                  reset,
  sp_mac_chain_ctrl_if.slave   bus
);
  localparam int FW = $clog2(N_UNITS + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DONE} state_t;
  state_t        state, state_n;
  logic [KW-1:0] klen_q, klen_n, bcnt, bcnt_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic          rst_q, rst_n, pulse_q, pulse_n;
  logic [3:0]    a1_q, a1_n, a2_q, a2_n;
  logic [7:0]    b1_q, b1_n, b2_q, b2_n;
  logic [8:0]    mix_q, mix_n;
  always_comb begin
    state_n = state;
    klen_n  = klen_q;
    bcnt_n  = bcnt;
    fcnt_n  = fcnt;
    rst_n   = 1'b0;
    pulse_n = 1'b0;
    a1_n    = a1_q;
    a2_n    = a2_q;
    b1_n    = b1_q;
    b2_n    = b2_q;
    mix_n   = mix_q;
    case (state)
      IDLE: if (bus.start && !bus.abort) begin
        state_n = CLEAR;
        klen_n  = bus.k_len;
        bcnt_n  = '0;
        fcnt_n  = '0;
        rst_n   = 1'b1;
      end
      CLEAR: state_n = (klen_q == '0) ? DONE : FEED;
      FEED: if (bus.in_valid) begin
        pulse_n = 1'b1;
        a1_n    = bus.in_a1;
        a2_n    = bus.in_a2;
        b1_n    = bus.in_b1;
        b2_n    = bus.in_b2;
        mix_n   = {1'b0, bus.in_b1} + {1'b0, bus.in_b2};
        bcnt_n  = bcnt + KW'(1);
        state_n = (bcnt_n == klen_q) ? FLUSH : FEED;
      end
      // Final FLUSH cycle issues no pulse so DONE follows the last pulse cycle.
      FLUSH: if (fcnt == FW'(N_UNITS - 1)) state_n = DONE;
      else begin
        pulse_n = 1'b1;
        a1_n    = '0;
        a2_n    = '0;
        b1_n    = '0;
        b2_n    = '0;
        mix_n   = '0;
        fcnt_n  = fcnt + FW'(1);
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state != IDLE && bus.abort) begin
      state_n = IDLE;
      rst_n   = 1'b1;
      pulse_n = 1'b0;
      a1_n    = '0;
      a2_n    = '0;
      b1_n    = '0;
      b2_n    = '0;
      mix_n   = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      klen_q  <= '0;
      bcnt    <= '0;
      fcnt    <= '0;
      rst_q   <= 1'b0;
      pulse_q <= 1'b0;
      a1_q    <= '0;
      a2_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      mix_q   <= '0;
    end else begin
      state   <= state_n;
      klen_q  <= klen_n;
      bcnt    <= bcnt_n;
      fcnt    <= fcnt_n;
      rst_q   <= rst_n;
      pulse_q <= pulse_n;
      a1_q    <= a1_n;
      a2_q    <= a2_n;
      b1_q    <= b1_n;
      b2_q    <= b2_n;
      mix_q   <= mix_n;
    end
  end
  assign bus.busy      = state != IDLE;
  assign bus.done      = state == DONE;
  assign bus.in_ready  = state == FEED;
  assign bus.mac_rst   = rst_q;
  assign bus.mac_pulse = pulse_q;
  assign bus.mac_a1    = a1_q;
  assign bus.mac_a2    = a2_q;
  assign bus.mac_b1    = b1_q;
  assign bus.mac_b2    = b2_q;
  assign bus.mac_mix   = mix_q;
endmodule

// File: tb/tb_sp_mac_chain_ctrl.sv
// tb_sp_mac_chain_ctrl: directed checks of job sequencing, stalls, abort and mix arithmetic
module tb_sp_mac_chain_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] bb1, bb2;
  logic [8:0] exp_mix;
  int   pulses, done_at, dones;
  sp_mac_chain_ctrl_if #(.KW(16)) bus ();
  sp_mac_chain_ctrl #(.N_UNITS(4), .KW(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Runs one job; start sampled at edge E0, loop index c is the cycle number after E0.
  task automatic job(input int k, input int st_after, input int st_len,
                     output int np, output int dat, output int nd);
    int sent = 0;
    int stalled = 0;
    np = 0; dat = -1; nd = 0;
    bus.start = 1'b1; bus.k_len = 16'(k);
    tick();
    bus.start = 1'b0;
    chk("clear_rst", bus.mac_rst, 1);
    chk("clear_busy", bus.busy, 1);
    chk("clear_rdy", bus.in_ready, 0);
    for (int c = 2; c < 60 && !(dat > 0 && c > dat + 1); c++) begin
      bus.in_valid = (sent < k) && !(sent == st_after && stalled < st_len);
      bus.in_a1 = 4'd1; bus.in_a2 = 4'd2; bus.in_b1 = bb1; bus.in_b2 = bb2;
      if (bus.in_ready && sent == st_after && !bus.in_valid) stalled++;
      if (bus.in_ready && bus.in_valid) sent++;
      tick();
      if (c == 2) chk("ready_e2", bus.in_ready, k != 0);
      if (bus.mac_pulse) begin
        np++;
        chk("pulse_mix", bus.mac_mix, np <= k ? exp_mix : 9'd0);
        chk("pulse_a1", bus.mac_a1, np <= k ? 1 : 0);
      end else if (sent > 0 && sent < k) chk("stall_hold", bus.mac_mix, exp_mix);
      if (bus.done) begin
        nd++;
        if (dat < 0) dat = c;
      end
    end
    bus.in_valid = 1'b0;
  endtask
  initial begin
    bus.start = 1'b1; bus.abort = 1'b0; bus.k_len = 16'd3; bus.in_valid = 1'b1;
    bus.in_a1 = 4'd7; bus.in_a2 = 4'd7; bus.in_b1 = 8'd9; bus.in_b2 = 8'd9;
    tick(); tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_macrst", bus.mac_rst, 0);
    chk("rst_pulse", bus.mac_pulse, 0);
    chk("rst_mix", bus.mac_mix, 0);
    chk("rst_a1", bus.mac_a1, 0);
    bus.start = 1'b0; bus.in_valid = 1'b0;
    reset = 1'b0;
    tick(); tick(); tick();
    chk("idle_busy", bus.busy, 0);
    chk("idle_ready", bus.in_ready, 0);
    chk("idle_pulse", bus.mac_pulse, 0);
    bb1 = 8'd10; bb2 = 8'd20; exp_mix = 9'd30;
    job(3, -1, 0, pulses, done_at, dones);
    chk("base_pulses", pulses, 6);
    chk("base_done_at", done_at, 9);
    chk("base_done_len", dones, 1);
    chk("base_busy_after", bus.busy, 0);
    job(3, 1, 2, pulses, done_at, dones);
    chk("stall_pulses", pulses, 6);
    chk("stall_done_at", done_at, 11);
    chk("stall_done_len", dones, 1);
    job(0, -1, 0, pulses, done_at, dones);
    chk("k0_pulses", pulses, 0);
    chk("k0_done_at", done_at, 2);
    bb1 = 8'd255; bb2 = 8'd255; exp_mix = 9'h1FE;
    job(1, -1, 0, pulses, done_at, dones);
    chk("max_pulses", pulses, 4);
    chk("max_done_at", done_at, 7);
    bb1 = 8'd0; bb2 = 8'd0; exp_mix = 9'd0;
    job(2, -1, 0, pulses, done_at, dones);
    chk("zero_pulses", pulses, 5);
    chk("zero_done_at", done_at, 8);
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("startabort_busy", bus.busy, 0);
    chk("startabort_rst", bus.mac_rst, 0);
    bus.start = 1'b1; bus.k_len = 16'd5;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_a1 = 4'd3; bus.in_a2 = 4'd4; bus.in_b1 = 8'd5; bus.in_b2 = 8'd6;
    tick(); tick();
    chk("abort_pre_pulse", bus.mac_pulse, 1);
    chk("abort_pre_mix", bus.mac_mix, 11);
    tick();
    bus.in_valid = 1'b0; bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_rst", bus.mac_rst, 1);
    chk("abort_pulse", bus.mac_pulse, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_mix", bus.mac_mix, 0);
    chk("abort_a1", bus.mac_a1, 0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done) dones++;
    end
    chk("abort_no_done", dones, 0);
    bb1 = 8'd10; bb2 = 8'd20; exp_mix = 9'd30;
    job(3, -1, 0, pulses, done_at, dones);
    chk("post_abort_pulses", pulses, 6);
    chk("post_abort_done_at", done_at, 9);
    bus.start = 1'b1; bus.k_len = 16'd4;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b1;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_pulse", bus.mac_pulse, 0);
    chk("midrst_mix", bus.mac_mix, 0);
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_idle", bus.in_ready, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
